// File: rtl/serial_sub_defs.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_defs;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // One extra bit beyond clog2 so the count never needs to wrap.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two half-subtractor stages and an OR,
// usable on its own or chained into a ripple subtractor.
module full_subtractor (
    input  logic input_a_i,
    input  logic input_b_i,
    input  logic borrow_in_i,
    output logic diff_o,
    output logic borrow_o
);

    logic hs1_diff;
    logic hs1_borrow;
    logic hs2_borrow;

    assign hs1_diff   = input_a_i ^ input_b_i;
    assign hs1_borrow = ~input_a_i & input_b_i;

    assign diff_o     = hs1_diff ^ borrow_in_i;
    assign hs2_borrow = ~hs1_diff & borrow_in_i;

    assign borrow_o   = hs1_borrow | hs2_borrow;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: one full-subtractor cell and a
// registered borrow compute A - B over WIDTH cycles behind a start/busy/done handshake.
module serial_subtractor
    import serial_sub_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] difference_o,
    output logic             borrow_out_o
);

    localparam int                 CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-2:0]   sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               borrow_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               done_q;

    logic               fs_diff;
    logic               fs_borrow;
    logic [WIDTH-1:0]   sr_d;

    full_subtractor u_fs (
        .input_a_i   (sa_q[0]),
        .input_b_i   (sb_q[0]),
        .borrow_in_i (borrow_q),
        .diff_o      (fs_diff),
        .borrow_o    (fs_borrow)
    );

    // Only the upper WIDTH-1 result bits need storage; the newest bit comes
    // straight from the cell so the final edge can publish the full result.
    assign sr_d = {fs_diff, sr_q};

    // Control FSM plus serial datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sa_q     <= operand_a_i;
                        sb_q     <= operand_b_i;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    sa_q     <= {1'b0, sa_q[WIDTH-1:1]};
                    sb_q     <= {1'b0, sb_q[WIDTH-1:1]};
                    sr_q     <= sr_d[WIDTH-1:1];
                    borrow_q <= fs_borrow;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= sr_d;
                        bout_q  <= fs_borrow;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign difference_o = diff_q;
    assign borrow_out_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected
// {borrow, difference}; a negedge monitor pops and compares on every Done.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;
    int cyc      = 0;

    logic [W:0] exp_q[$];
    logic [W:0] mon_e;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .operand_a_i  (a),
        .operand_b_i  (b),
        .busy_o       (busy),
        .done_o       (done),
        .difference_o (diff),
        .borrow_out_o (borrow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=timeout required=finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done actual=%0h required=no_done", {borrow, diff});
            end else begin
                mon_e = exp_q.pop_front();
                if ({borrow, diff} !== mon_e) begin
                    bad++;
                    $display("FAIL result actual=%0h required=%0h", {borrow, diff}, mon_e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (i == 40) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Single directed operation with latency / busy-length / hold checks.
    task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W:0] e);
        int n;
        int busy_n;
        wait_idle();
        start = 1'b1; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(e);
        acc_cnt++;
        a = ~va; b = ~vb;
        chk("busy_after_capture", 32'(busy), 32'd1);
        n = 0; busy_n = 1;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (busy) busy_n++;
            if (done) break;
        end
        chk("done_latency", 32'(n), 32'd8);
        chk("busy_cycles", 32'(busy_n), 32'd9);
        @(posedge clk); #1;
        chk("done_single", 32'(done), 32'd0);
        chk("busy_release", 32'(busy), 32'd0);
        chk("result_hold", 32'({borrow, diff}), 32'(e));
    endtask

    initial begin
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W:0]   e;
        int           d0;
        int           last_cap;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_diff",   32'(diff),   32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        op(8'h5A, 8'h23, 9'h037);
        op(8'h00, 8'h01, 9'h1FF);
        op(8'hFF, 8'hFF, 9'h000);
        op(8'h80, 8'h7F, 9'h001);

        // Start re-asserted while busy with wandering operands is ignored.
        wait_idle();
        d0 = done_cnt;
        start = 1'b1; a = 8'h10; b = 8'h05;
        @(posedge clk); #1;
        exp_q.push_back(9'h00B);
        acc_cnt++;
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            a = W'($urandom); b = W'($urandom);
            start = (i == 2 || i == 3);
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("ignore_one_done", 32'(done_cnt - d0), 32'd1);
        chk("ignore_result", 32'({borrow, diff}), 32'h00B);

        // Asynchronous reset mid-RUN aborts with no Done.
        start = 1'b1; a = 8'h33; b = 8'h11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_done",   32'(done),   32'd0);
        chk("abort_diff",   32'(diff),   32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        op(8'h09, 8'h0C, 9'h1FD);

        // Back-to-back with Start held high: directed then random operands.
        last_cap = 0;
        start = 1'b1;
        for (int j = 0; j < 300; j++) begin
            case (j)
                0:       begin va = 8'h01; vb = 8'h02; end
                1:       begin va = 8'hC8; vb = 8'h64; end
                2:       begin va = 8'h7F; vb = 8'h80; end
                default: begin va = W'($urandom); vb = W'($urandom); end
            endcase
            a = va; b = vb;
            e = {1'b0, va} - {1'b0, vb};
            wait_idle();
            @(posedge clk); #1;
            exp_q.push_back(e);
            acc_cnt++;
            if (j < 3) chk("b2b_busy", 32'(busy), 32'd1);
            if (j > 0) chk("b2b_spacing", 32'(cyc - last_cap), 32'd10);
            last_cap = cyc;
            a = ~va; b = ~vb;
        end
        start = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("done_vs_accepted", 32'(done_cnt), 32'(acc_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
